// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder sequencer.
package bcd_pkg;

  localparam int         DIG_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bad_digit(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial BCD adder sequencer.
interface bcd_serial_add_ctrl_if #(
  parameter int NDIG = 4
);

  logic                  start_i;
  logic [4*NDIG-1:0]     a_i;
  logic [4*NDIG-1:0]     b_i;
  logic                  cin_i;
  logic                  ready_o;
  logic                  done_o;
  logic [4*NDIG-1:0]     sum_o;
  logic                  cout_o;
  logic                  err_o;

  modport master (
    output start_i, a_i, b_i, cin_i,
    input  ready_o, done_o, sum_o, cout_o, err_o
  );

  modport slave (
    input  start_i, a_i, b_i, cin_i,
    output ready_o, done_o, sum_o, cout_o, err_o
  );

endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder sequencer: walks one shared external digit adder across
// NDIG digit pairs, least-significant first, rippling the decimal carry.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; operands latched on start_i
//   RUN   | one digit per cycle through the shared adder, idx = digit
//   DONE  | result valid, done_o pulses for this single cycle
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_add_ctrl_if.slave bus,
  output logic [3:0]          add_a_o,
  output logic [3:0]          add_b_o,
  output logic                add_cin_o,
  input  logic [3:0]          add_sum_i,
  input  logic                add_cout_i
);

  localparam int CNT_W = $clog2(NDIG);
  localparam int OP_W  = DIG_W * NDIG;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q,   idx_d;
  logic [OP_W-1:0]  opa_q,   opa_d;
  logic [OP_W-1:0]  opb_q,   opb_d;
  logic             carry_q, carry_d;
  logic [OP_W-1:0]  sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             err_q,   err_d;
  logic             in_bad;

  // Flag any non-decimal digit on either incoming operand.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      in_bad = in_bad | is_bad_digit(bus.a_i[i*DIG_W +: DIG_W])
                      | is_bad_digit(bus.b_i[i*DIG_W +: DIG_W]);
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          opa_d   = bus.a_i;
          opb_d   = bus.b_i;
          carry_d = bus.cin_i;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = in_bad;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*DIG_W +: DIG_W] = add_sum_i;
        carry_d = add_cout_i;
        if (idx_q == LAST_IDX) begin
          // The top digit's carry leaves only on cout_o; it never wraps.
          cout_d  = add_cout_i;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shared adder is driven only while digits are being processed.
  always_comb begin
    add_a_o   = 4'd0;
    add_b_o   = 4'd0;
    add_cin_o = 1'b0;
    if (state_q == RUN) begin
      add_a_o   = opa_q[idx_q*DIG_W +: DIG_W];
      add_b_o   = opb_q[idx_q*DIG_W +: DIG_W];
      add_cin_o = carry_q;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.done_o  = (state_q == DONE);
  assign bus.sum_o   = sum_q;
  assign bus.cout_o  = cout_q;
  assign bus.err_o   = err_q;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl with a behavioural BCD digit adder on add_*.
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [5:0]  t_raw, t_adj;

  int nvec = 0;
  int nerr = 0;
  vec_t sb_q[$];
  vec_t vecs[10];

  bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_cin_o  (add_cin),
    .add_sum_i  (add_sum),
    .add_cout_i (add_cout)
  );

  // Behavioural single-digit decimal adder.
  always_comb begin
    t_raw = {2'b00, add_a} + {2'b00, add_b} + {5'b00000, add_cin};
    t_adj = t_raw + 6'd6;
    if (t_raw > 6'd9) begin
      add_sum  = t_adj[3:0];
      add_cout = 1'b1;
    end else begin
      add_sum  = t_raw[3:0];
      add_cout = 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done_o pulse retires the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("sum", bus.sum_o, e.sum);
        chk("cout", bus.cout_o, e.cout);
        chk("err", bus.err_o, e.err);
      end
    end
  end

  task automatic run_op(input vec_t v);
    bit got;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("ready_timeout", 0, 1);
    bus.a_i = v.a;
    bus.b_i = v.b;
    bus.cin_i = v.cin;
    bus.start_i = 1'b1;
    @(posedge clk);
    sb_q.push_back(v);
    #1;
    chk("run0_add_a", add_a, v.a[3:0]);
    chk("run0_add_b", add_b, v.b[3:0]);
    chk("run0_add_cin", add_cin, v.cin);
    chk("run0_ready", bus.ready_o, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i = 16'($urandom);
    bus.b_i = 16'($urandom);
    bus.cin_i = 1'($urandom);
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        got = 1'b1;
        chk("latency_edges", k, NDIG);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("held_sum", bus.sum_o, v.sum);
    chk("idle_ready", bus.ready_o, 1);
    chk("idle_add_a", add_a, 0);
    chk("idle_done", bus.done_o, 0);
  endtask

  initial begin
    int dn;
    int rl;
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'h00C0, 16'h0011, 1'b0, 16'h0131, 1'b0, 1'b1};
    vecs[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h4567, 16'h4433, 1'b0, 16'h9000, 1'b0, 1'b0};
    vecs[7] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'hA000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.start_i = 1'b1;
    bus.a_i = 16'h1234;
    bus.b_i = 16'h1111;
    bus.cin_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_done", bus.done_o, 0);
    chk("rst_sum", bus.sum_o, 0);
    chk("rst_cout", bus.cout_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_add_a", add_a, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // start_i held for 8 cycles: one op, then a second accepted only from IDLE.
    @(negedge clk);
    bus.a_i = vecs[0].a;
    bus.b_i = vecs[0].b;
    bus.cin_i = vecs[0].cin;
    bus.start_i = 1'b1;
    dn = 0;
    rl = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      if (c == 1 || c == 7) sb_q.push_back(vecs[0]);
      #1;
      if (bus.done_o) dn++;
      if (c <= 6 && !bus.ready_o) rl++;
      if (c == 6) chk("hold_ready_back", bus.ready_o, 1);
      if (c == 7) chk("hold_second_accept", bus.ready_o, 0);
    end
    chk("hold_done_pulses", dn, 1);
    chk("hold_ready_low", rl, 5);
    @(negedge clk);
    bus.start_i = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dn++;
    end
    chk("hold_second_done", dn, 1);

    // Reset during the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    bus.a_i = 16'h1234;
    bus.b_i = 16'h5678;
    bus.cin_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_sum", bus.sum_o, 0);
    chk("abort_cout", bus.cout_o, 0);
    chk("abort_ready", bus.ready_o, 1);
    chk("abort_done", bus.done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dn++;
    end
    chk("abort_no_done", dn, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
